// File: rtl/mprc_wb_unit.sv
// Writeback unit: evicts one dirty victim block by reading its metadata slot,
// then its data rows, and forwarding each row as a release beat.
module mprc_wb_unit #(
  parameter int ROW_BITS = 128,
  parameter int BEATS    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [19:0]                req_tag,
  input  logic [5:0]                 req_idx,
  input  logic [3:0]                 req_way_en,
  input  logic                       req_voluntary,
  output logic                       wb_io_meta_read_valid,
  input  logic                       wb_io_meta_read_ready,
  output logic [5:0]                 wb_io_meta_read_bits_idx,
  output logic [19:0]                wb_io_meta_read_bits_tag,
  output logic                       wb_io_data_req_valid,
  input  logic                       wb_io_data_req_ready,
  output logic [3:0]                 wb_io_data_req_bits_way_en,
  output logic [11:0]                wb_io_data_req_bits_addr,
  input  logic [ROW_BITS-1:0]        data_io_resp_0,
  input  logic [ROW_BITS-1:0]        data_io_resp_1,
  input  logic [ROW_BITS-1:0]        data_io_resp_2,
  input  logic [ROW_BITS-1:0]        data_io_resp_3,
  output logic                       release_valid,
  input  logic                       release_ready,
  output logic [25:0]                release_addr_block,
  output logic [$clog2(BEATS)-1:0]   release_beat,
  output logic [ROW_BITS-1:0]        release_data,
  output logic                       release_voluntary,
  output logic                       busy,
  output logic [5:0]                 busy_idx
);

  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_META,
    S_DATA
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [19:0]         r_tag;
  logic [5:0]          r_idx;
  logic [3:0]          r_way_en;
  logic                r_voluntary;
  logic [CNT_W:0]      r_issue_cnt;
  logic                r_inflight;
  logic                r_buf_valid;
  logic [CNT_W-1:0]    r_buf_beat;
  logic [ROW_BITS-1:0] r_buf_data;

  logic                w_req_fire;
  logic                w_data_fire;
  logic                w_rel_fire;
  logic                w_last_fire;
  logic [ROW_BITS-1:0] w_resp [4];
  logic [ROW_BITS-1:0] w_row_sel;

  assign w_req_fire  = req_valid & (r_state == S_IDLE);
  // issue_cnt MSB set means all BEATS rows have been requested
  assign wb_io_data_req_valid = (r_state == S_DATA) & ~r_issue_cnt[CNT_W] &
                                ~r_inflight & ~r_buf_valid;
  assign w_data_fire = wb_io_data_req_valid & wb_io_data_req_ready;
  assign w_rel_fire  = r_buf_valid & release_ready;
  assign w_last_fire = w_rel_fire & (r_buf_beat == CNT_W'(BEATS - 1));

  assign w_resp[0] = data_io_resp_0;
  assign w_resp[1] = data_io_resp_1;
  assign w_resp[2] = data_io_resp_2;
  assign w_resp[3] = data_io_resp_3;

  // AND-OR way select; a non-one-hot way_en ORs the chosen rows together
  always_comb begin
    w_row_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_way_en[i]) w_row_sel = w_row_sel | w_resp[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)             w_state_nxt = S_META;
      S_META:  if (wb_io_meta_read_ready) w_state_nxt = S_DATA;
      S_DATA:  if (w_last_fire)           w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag       <= '0;
      r_idx       <= '0;
      r_way_en    <= '0;
      r_voluntary <= 1'b0;
      r_issue_cnt <= '0;
      r_inflight  <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_beat  <= '0;
      r_buf_data  <= '0;
    end else begin
      if (w_req_fire) begin
        r_tag       <= req_tag;
        r_idx       <= req_idx;
        r_way_en    <= req_way_en;
        r_voluntary <= req_voluntary;
        r_issue_cnt <= '0;
        r_inflight  <= 1'b0;
        r_buf_valid <= 1'b0;
      end
      if (w_data_fire) begin
        r_inflight  <= 1'b1;
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      // the row read granted last cycle is on the array outputs now
      if (r_inflight) begin
        r_buf_data  <= w_row_sel;
        r_buf_beat  <= r_issue_cnt[CNT_W-1:0] - 1'b1;
        r_buf_valid <= 1'b1;
        r_inflight  <= 1'b0;
      end
      if (w_rel_fire) r_buf_valid <= 1'b0;
    end
  end

  assign req_ready                  = (r_state == S_IDLE);
  assign busy                       = (r_state != S_IDLE);
  assign busy_idx                   = r_idx;
  assign wb_io_meta_read_valid      = (r_state == S_META);
  assign wb_io_meta_read_bits_idx   = r_idx;
  assign wb_io_meta_read_bits_tag   = r_tag;
  assign wb_io_data_req_bits_way_en = r_way_en;
  assign wb_io_data_req_bits_addr   = {r_idx, r_issue_cnt[CNT_W-1:0], 4'b0000};
  assign release_valid              = r_buf_valid;
  assign release_addr_block         = {r_tag, r_idx};
  assign release_beat               = r_buf_beat;
  assign release_data               = r_buf_data;
  assign release_voluntary          = r_voluntary;

endmodule

// File: tb/tb_mprc_wb_unit.sv
// Directed bench for mprc_wb_unit: evictions with meta/data/release stalls,
// back-to-back requests and a mid-transaction reset.
module tb_mprc_wb_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [19:0]  req_tag;
  logic [5:0]   req_idx;
  logic [3:0]   req_way_en;
  logic         req_voluntary;
  logic         meta_valid;
  logic         meta_ready;
  logic [5:0]   meta_idx;
  logic [19:0]  meta_tag;
  logic         data_valid;
  logic         data_ready;
  logic [3:0]   data_way;
  logic [11:0]  data_addr;
  logic [127:0] resp0, resp1, resp2, resp3;
  logic         rel_valid;
  logic         rel_ready;
  logic [25:0]  rel_blk;
  logic [1:0]   rel_beat;
  logic [127:0] rel_data;
  logic         rel_vol;
  logic         busy;
  logic [5:0]   busy_idx;

  always #5 clk = ~clk;

  mprc_wb_unit #(.ROW_BITS(128), .BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_idx(req_idx), .req_way_en(req_way_en), .req_voluntary(req_voluntary),
    .wb_io_meta_read_valid(meta_valid), .wb_io_meta_read_ready(meta_ready),
    .wb_io_meta_read_bits_idx(meta_idx), .wb_io_meta_read_bits_tag(meta_tag),
    .wb_io_data_req_valid(data_valid), .wb_io_data_req_ready(data_ready),
    .wb_io_data_req_bits_way_en(data_way), .wb_io_data_req_bits_addr(data_addr),
    .data_io_resp_0(resp0), .data_io_resp_1(resp1),
    .data_io_resp_2(resp2), .data_io_resp_3(resp3),
    .release_valid(rel_valid), .release_ready(rel_ready),
    .release_addr_block(rel_blk), .release_beat(rel_beat),
    .release_data(rel_data), .release_voluntary(rel_vol),
    .busy(busy), .busy_idx(busy_idx)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Row contents the bench's data array returns for way k at row address a
  function automatic logic [127:0] pat(input int k, input logic [11:0] a);
    return {32'hC0DE_0000 | 32'(k), 20'h0, a, ~{20'h0, a}, 32'h5EED_0000 + 32'(k)};
  endfunction

  // Event logs
  int           fq_cyc[$];
  int           rise_cyc[$];
  int           mq_cyc[$];
  logic [5:0]   mq_idx[$];
  logic [19:0]  mq_tag[$];
  int           dq_cyc[$];
  logic [11:0]  dq_addr[$];
  logic [3:0]   dq_way[$];
  int           rq_cyc[$];
  logic [1:0]   rq_beat[$];
  logic [127:0] rq_data[$];
  logic [25:0]  rq_blk[$];
  logic         rq_vol[$];

  // Monitor / driver state
  logic         pm_stall = 1'b0, pd_stall = 1'b0, pr_stall = 1'b0, prev_rdy = 1'b1;
  logic [5:0]   pm_idx;
  logic [19:0]  pm_tag;
  logic [11:0]  pd_addr;
  logic [3:0]   pd_way;
  logic [127:0] pr_data;
  logic [1:0]   pr_beat;
  logic         d_pend = 1'b0;
  logic [11:0]  d_addr;
  logic [5:0]   exp_busy_idx = '0;
  int cfg_ms_left = 0, cfg_dsb = -1, cfg_ds_left = 0, cfg_rsb = -1, cfg_rs_left = 0;
  int cfg_db = 0, cfg_rb = 0;

  task automatic sample();
    if (!reset) begin
      pm_stall = 1'b0; pd_stall = 1'b0; pr_stall = 1'b0;
      prev_rdy = req_ready;
    end else begin
      if (pm_stall) begin
        chk("meta_hold_valid", 128'(meta_valid), 128'(1));
        chk("meta_hold_idx", 128'(meta_idx), 128'(pm_idx));
        chk("meta_hold_tag", 128'(meta_tag), 128'(pm_tag));
      end
      if (pd_stall) begin
        chk("dreq_hold_valid", 128'(data_valid), 128'(1));
        chk("dreq_hold_addr", 128'(data_addr), 128'(pd_addr));
        chk("dreq_hold_way", 128'(data_way), 128'(pd_way));
      end
      if (pr_stall) begin
        chk("rel_hold_valid", 128'(rel_valid), 128'(1));
        chk("rel_hold_data", rel_data, pr_data);
        chk("rel_hold_beat", 128'(rel_beat), 128'(pr_beat));
      end
      if (data_valid) chk("dreq_while_rel", 128'(rel_valid), 128'(0));
      chk("busy_vs_ready", 128'(busy), 128'(!req_ready));
      if (busy) chk("busy_idx", 128'(busy_idx), 128'(exp_busy_idx));
      if (req_valid && req_ready) fq_cyc.push_back(cyc);
      if (req_ready && !prev_rdy) rise_cyc.push_back(cyc);
      if (meta_valid && meta_ready) begin
        mq_cyc.push_back(cyc); mq_idx.push_back(meta_idx); mq_tag.push_back(meta_tag);
      end
      if (data_valid && data_ready) begin
        dq_cyc.push_back(cyc); dq_addr.push_back(data_addr); dq_way.push_back(data_way);
        d_pend = 1'b1; d_addr = data_addr;
      end
      if (rel_valid && rel_ready) begin
        rq_cyc.push_back(cyc); rq_beat.push_back(rel_beat); rq_data.push_back(rel_data);
        rq_blk.push_back(rel_blk); rq_vol.push_back(rel_vol);
      end
      pm_stall = meta_valid && !meta_ready; pm_idx = meta_idx; pm_tag = meta_tag;
      pd_stall = data_valid && !data_ready; pd_addr = data_addr; pd_way = data_way;
      pr_stall = rel_valid && !rel_ready;   pr_data = rel_data;  pr_beat = rel_beat;
      prev_rdy = req_ready;
    end
  endtask

  // One clock: sample at the falling edge, drive array rows and readies after the rise
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    if (d_pend) begin
      resp0 = pat(0, d_addr); resp1 = pat(1, d_addr);
      resp2 = pat(2, d_addr); resp3 = pat(3, d_addr);
    end else begin
      resp0 = '1; resp1 = '1; resp2 = '1; resp3 = '1;
    end
    d_pend = 1'b0;
    meta_ready = 1'b1;
    if (meta_valid && cfg_ms_left > 0) begin
      meta_ready = 1'b0; cfg_ms_left--;
    end
    data_ready = 1'b1;
    if (data_valid && (dq_cyc.size() - cfg_db) == cfg_dsb && cfg_ds_left > 0) begin
      data_ready = 1'b0; cfg_ds_left--;
    end
    rel_ready = 1'b1;
    if (rel_valid && (rq_cyc.size() - cfg_rb) == cfg_rsb && cfg_rs_left > 0) begin
      rel_ready = 1'b0; cfg_rs_left--;
    end
  endtask

  task automatic issue(input logic [5:0] idx, input logic [19:0] tg, input logic [3:0] way,
                       input logic vol, output int mb, output int db, output int rb,
                       output int ib, output int fb);
    mb = mq_cyc.size(); db = dq_cyc.size(); rb = rq_cyc.size();
    ib = rise_cyc.size(); fb = fq_cyc.size();
    cfg_db = db; cfg_rb = rb;
    chk("idle_before_req", 128'(req_ready), 128'(1));
    req_idx = idx; req_tag = tg; req_way_en = way; req_voluntary = vol;
    req_valid = 1'b1;
    exp_busy_idx = idx;
    tick();
  endtask

  task automatic wait_done(input string nm, input int rb);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      if (rq_cyc.size() >= rb + 4 && req_ready) begin
        done = 1;
        break;
      end
      tick();
    end
    chk({nm, "_completes"}, 128'(done), 128'(1));
    tick();
  endtask

  task automatic verify(input string nm, input int t, input int mb, input int db,
                        input int rb, input int ib, input logic [5:0] idx,
                        input logic [19:0] tg, input logic [3:0] way, input logic vol,
                        input int ms, input int dsb, input int dsn,
                        input int rsb, input int rsn);
    int me, idle, w;
    int d[4];
    int r[4];
    logic [11:0] a;
    w = 0;
    for (int k = 0; k < 4; k++) if (way[k]) w = k;
    me = t + 1 + ms;
    for (int b = 0; b < 4; b++) begin
      d[b] = ((b == 0) ? me + 1 : r[b-1] + 1) + ((b == dsb) ? dsn : 0);
      r[b] = d[b] + 2 + ((b == rsb) ? rsn : 0);
    end
    idle = r[3] + 1;
    if (mq_cyc.size() <= mb || dq_cyc.size() < db + 4 || rq_cyc.size() < rb + 4 ||
        rise_cyc.size() <= ib) begin
      chk({nm, "_event_count"}, 128'(0), 128'(1));
    end else begin
      chk({nm, "_meta_cyc"}, 128'(mq_cyc[mb]), 128'(me));
      chk({nm, "_meta_idx"}, 128'(mq_idx[mb]), 128'(idx));
      chk({nm, "_meta_tag"}, 128'(mq_tag[mb]), 128'(tg));
      for (int b = 0; b < 4; b++) begin
        a = {idx, 2'(b), 4'h0};
        chk({nm, "_dreq_cyc"},  128'(dq_cyc[db+b]),  128'(d[b]));
        chk({nm, "_dreq_addr"}, 128'(dq_addr[db+b]), 128'(a));
        chk({nm, "_dreq_way"},  128'(dq_way[db+b]),  128'(way));
        chk({nm, "_rel_cyc"},   128'(rq_cyc[rb+b]),  128'(r[b]));
        chk({nm, "_rel_beat"},  128'(rq_beat[rb+b]), 128'(b));
        chk({nm, "_rel_data"},  rq_data[rb+b],       pat(w, a));
        chk({nm, "_rel_block"}, 128'(rq_blk[rb+b]),  128'({tg, idx}));
        chk({nm, "_rel_vol"},   128'(rq_vol[rb+b]),  128'(vol));
      end
      chk({nm, "_ready_again"}, 128'(rise_cyc[ib]), 128'(idle));
    end
  endtask

  task automatic run(input string nm, input logic [5:0] idx, input logic [19:0] tg,
                     input logic [3:0] way, input logic vol, input int ms,
                     input int dsb, input int dsn, input int rsb, input int rsn);
    int mb, db, rb, ib, fb;
    cfg_ms_left = ms; cfg_dsb = dsb; cfg_ds_left = dsn; cfg_rsb = rsb; cfg_rs_left = rsn;
    issue(idx, tg, way, vol, mb, db, rb, ib, fb);
    req_valid = 1'b0;
    wait_done(nm, rb);
    if (fq_cyc.size() > fb)
      verify(nm, fq_cyc[fb], mb, db, rb, ib, idx, tg, way, vol, ms, dsb, dsn, rsb, rsn);
    else
      chk({nm, "_accepted"}, 128'(0), 128'(1));
    cfg_dsb = -1; cfg_rsb = -1;
  endtask

  initial begin
    int mb, db, rb, ib, fb, mb2, db2, rb2, ib2, fb2;
    bit got;
    reset = 1'b1;
    req_valid = 1'b0; req_tag = '0; req_idx = '0; req_way_en = '0; req_voluntary = 1'b0;
    meta_ready = 1'b1; data_ready = 1'b1; rel_ready = 1'b1;
    resp0 = '1; resp1 = '1; resp2 = '1; resp3 = '1;
    #2 reset = 1'b0;
    #2;
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_meta_valid", 128'(meta_valid), 128'(0));
    chk("rst_dreq_valid", 128'(data_valid), 128'(0));
    chk("rst_rel_valid", 128'(rel_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_busy_idx", 128'(busy_idx), 128'(0));
    chk("rst_rel_data", rel_data, 128'(0));
    chk("rst_rel_block", 128'(rel_blk), 128'(0));
    chk("rst_rel_beat", 128'(rel_beat), 128'(0));
    chk("rst_dreq_addr", 128'(data_addr), 128'(0));
    #18 reset = 1'b1;
    tick(); tick();

    run("basic",   6'h2A, 20'h12345, 4'b0100, 1'b1, 0, -1, 0, -1, 0);
    run("mstall",  6'h2A, 20'h12345, 4'b0100, 1'b1, 5, -1, 0, -1, 0);
    run("dstall",  6'h2A, 20'h12345, 4'b0100, 1'b1, 0,  1, 4, -1, 0);
    run("rstall",  6'h2A, 20'h12345, 4'b0100, 1'b1, 0, -1, 0,  2, 6);

    // Back-to-back: second request held on req_valid while the first is busy
    issue(6'h2A, 20'h12345, 4'b0100, 1'b1, mb, db, rb, ib, fb);
    req_idx = 6'h01; req_tag = 20'h00777; req_way_en = 4'b0001; req_voluntary = 1'b0;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      if (fq_cyc.size() > fb + 1) begin
        got = 1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("b2b_second_accepted", 128'(got), 128'(1));
    if (got) begin
      exp_busy_idx = 6'h01;
      mb2 = mq_cyc.size(); db2 = dq_cyc.size(); rb2 = rq_cyc.size();
      ib2 = rise_cyc.size(); fb2 = fb + 1;
      cfg_db = db2; cfg_rb = rb2;
      verify("b2b_first", fq_cyc[fb], mb, db, rb, ib, 6'h2A, 20'h12345, 4'b0100, 1'b1,
             0, -1, 0, -1, 0);
      if (rq_cyc.size() >= rb + 4)
        chk("b2b_accept_cyc", 128'(fq_cyc[fb2]), 128'(rq_cyc[rb+3] + 1));
      wait_done("b2b_second", rb2);
      verify("b2b_second", fq_cyc[fb2], mb2, db2, rb2, ib2, 6'h01, 20'h00777, 4'b0001,
             1'b0, 0, -1, 0, -1, 0);
    end

    // Reset after the beat-1 release fire abandons the eviction
    issue(6'h15, 20'h0BEEF, 4'b1000, 1'b0, mb, db, rb, ib, fb);
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (rq_cyc.size() >= rb + 2) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("rstmid_reached_beat1", 128'(got), 128'(1));
    chk("rstmid_pre_busy", 128'(busy), 128'(1));
    #2 reset = 1'b0;
    #1;
    chk("rstmid_meta_valid", 128'(meta_valid), 128'(0));
    chk("rstmid_dreq_valid", 128'(data_valid), 128'(0));
    chk("rstmid_rel_valid", 128'(rel_valid), 128'(0));
    chk("rstmid_busy", 128'(busy), 128'(0));
    chk("rstmid_req_ready", 128'(req_ready), 128'(1));
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    chk("rstmid_no_more_rel", 128'(rq_cyc.size() - rb), 128'(2));
    chk("rstmid_ready_after", 128'(req_ready), 128'(1));
    run("after_rst", 6'h3F, 20'hABCDE, 4'b0010, 1'b0, 0, -1, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
